// File: rtl/st_arb_pkg.sv
// rtl/st_arb_pkg.sv - shared types and constants for the packet arbiter
package st_arb_pkg;

  localparam int MAX_IN     = 4;
  localparam int GIDX_W     = 2;
  localparam int DEF_DATA_W = 24;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/st_pkt_arbiter_if.sv
// rtl/st_pkt_arbiter_if.sv - source/sink streams, grant status and counters of the packet arbiter
interface st_pkt_arbiter_if
  import st_arb_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) ();

  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_startofpacket;
  logic [NUM_IN-1:0]        in_endofpacket;
  logic [NUM_IN-1:0]        in_ready;
  logic [NUM_IN-1:0]        in_enable;
  logic                     out_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_startofpacket;
  logic                     out_endofpacket;
  logic                     grant_valid;
  logic [GIDX_W-1:0]        grant_idx;
  logic                     sync_err;
  logic                     err_clr;
  logic [NUM_IN*CNT_W-1:0]  pkt_count;

  // environment side: drives sources, sink ready and error clear
  modport master (
    output in_valid, in_data, in_startofpacket, in_endofpacket, in_enable,
    output out_ready, err_clr,
    input  in_ready, out_valid, out_data, out_startofpacket, out_endofpacket,
    input  grant_valid, grant_idx, sync_err, pkt_count
  );

  // arbiter side
  modport slave (
    input  in_valid, in_data, in_startofpacket, in_endofpacket, in_enable,
    input  out_ready, err_clr,
    output in_ready, out_valid, out_data, out_startofpacket, out_endofpacket,
    output grant_valid, grant_idx, sync_err, pkt_count
  );

endinterface

// File: rtl/st_pkt_arbiter_rr_pick.sv
// rtl/st_pkt_arbiter_rr_pick.sv - combinational round-robin picker (rr_pick)
module rr_pick
  import st_arb_pkg::*;
#(
  parameter int NUM_IN = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [GIDX_W-1:0] last,
  output logic              any,
  output logic [GIDX_W-1:0] idx
);

  // search from last+1 upward with wrap; iterate farthest-first so the nearest requester wins
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (((int'(last) + k) % NUM_IN) == i && req[i]) begin
          idx = GIDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/st_pkt_arbiter.sv
// rtl/st_pkt_arbiter.sv - packet-level round-robin stream arbiter; ST_ARB_PKT_CNT_EN adds per-source packet counters
module st_pkt_arbiter
  import st_arb_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic              clk,
  input logic              reset_n,
  st_pkt_arbiter_if.slave  bus
);

  arb_state_e        state;
  logic [GIDX_W-1:0] last_grant;
  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] flush;
  logic [NUM_IN-1:0] sel;
  logic              pick_any;
  logic [GIDX_W-1:0] pick_idx;
  logic              eop_fire;

  assign req   = bus.in_valid &  bus.in_startofpacket & bus.in_enable;
  assign flush = bus.in_valid & ~bus.in_startofpacket & bus.in_enable;

  rr_pick #(.NUM_IN(NUM_IN)) u_pick (
    .req  (req),
    .last (last_grant),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // one-hot decode of the locked source
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      sel[i] = (bus.grant_idx == GIDX_W'(i));
    end
  end

  // zero-latency forwarding of the locked source; idle only drains stray mid-packet beats
  always_comb begin
    bus.out_valid         = 1'b0;
    bus.out_data          = '0;
    bus.out_startofpacket = 1'b0;
    bus.out_endofpacket   = 1'b0;
    bus.in_ready          = '0;
    if (reset_n) begin
      if (state == IDLE) begin
        bus.in_ready = flush;
      end else begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (sel[i]) begin
            bus.out_valid         = bus.in_valid[i];
            bus.out_data          = bus.in_data[i*DATA_W +: DATA_W];
            bus.out_startofpacket = bus.in_startofpacket[i];
            bus.out_endofpacket   = bus.in_endofpacket[i];
            bus.in_ready[i]       = bus.out_ready;
          end
        end
      end
    end
  end

  assign eop_fire = bus.out_valid & bus.out_ready & bus.out_endofpacket;

  // arbitration FSM: pick in IDLE, hold the grant until the accepted EOP
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      bus.grant_valid <= 1'b0;
      bus.grant_idx   <= '0;
      last_grant      <= GIDX_W'(NUM_IN - 1);
      bus.sync_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state           <= LOCK;
            bus.grant_idx   <= pick_idx;
            bus.grant_valid <= 1'b1;
          end
        end
        LOCK: begin
          if (eop_fire) begin
            state           <= IDLE;
            last_grant      <= bus.grant_idx;
            bus.grant_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (state == IDLE && |flush) begin
        bus.sync_err <= 1'b1;
      end else if (bus.err_clr) begin
        bus.sync_err <= 1'b0;
      end
    end
  end

`ifdef ST_ARB_PKT_CNT_EN
  logic [CNT_W-1:0] cnt [NUM_IN];

  // count accepted EOP beats per source, wrapping naturally
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_IN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (eop_fire && sel[i]) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // flatten counters onto the output bus
  always_comb begin
    bus.pkt_count = '0;
    for (int i = 0; i < NUM_IN; i++) bus.pkt_count[i*CNT_W +: CNT_W] = cnt[i];
  end
`else
  assign bus.pkt_count = {(NUM_IN*CNT_W){1'b0}};
`endif

endmodule

// File: doc/st_pkt_arbiter.md
Name: st_pkt_arbiter

Overview:
- Packet-level round-robin arbiter that shares one Avalon-ST sink between NUM_IN Avalon-ST sources. Beats are 24-bit pixel data with startofpacket/endofpacket.
- Sits upstream of the stream timing adapter. It merges video sources, such as test pattern, frame reader and camera path, onto one pipeline.
- Grant is held from SOP to the accepted EOP, so packets are never interleaved.
- Data path is combinational once granted. Arbitration costs one bubble cycle per packet.

Parameters:
- NUM_IN, 2, number of source ports (legal 2..4)
- DATA_W, 24, beat data width
- CNT_W, 16, packet counter width (used only with optional feature)

Ports:
- clk  in  1  single clock
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  NUM_IN  per-source valid
- in_data  in  NUM_IN*DATA_W  per-source data, source i at [i*DATA_W +: DATA_W]
- in_startofpacket  in  NUM_IN  per-source SOP
- in_endofpacket  in  NUM_IN  per-source EOP
- in_ready  out  NUM_IN  per-source ready
- in_enable  in  NUM_IN  per-source arbitration enable mask
- out_ready  in  1  sink ready
- out_valid  out  1  sink valid
- out_data  out  DATA_W  sink data
- out_startofpacket  out  1  sink SOP
- out_endofpacket  out  1  sink EOP
- grant_valid  out  1  a packet is locked
- grant_idx  out  2  index of locked or last source
- sync_err  out  1  sticky: a non-SOP beat was flushed while idle
- err_clr  in  1  clears sync_err
- pkt_count  out  NUM_IN*CNT_W  per-source completed packet count

Behaviour:
- Reset (reset_n=0 at clk edge):
  - state=IDLE, grant_valid=0, grant_idx=0, sync_err=0.
  - last_grant=NUM_IN-1, so source 0 has top priority first.
  - Counters cleared.
  - All combinational outputs forced low: out_valid=0, in_ready=0. out_data/SOP/EOP are 0.
- Reset mid-packet aborts the lock with no EOP emitted. The downstream block recovers on the next SOP.
- States: IDLE, LOCK.
- IDLE:
  - Request vector req[i] = in_valid[i] & in_startofpacket[i] & in_enable[i].
  - Winner = first set bit searching from last_grant+1 upward, wrapping modulo NUM_IN.
  - If any req: next state LOCK, grant_idx<=winner, grant_valid<=1.
  - No beat is transferred in IDLE; out_valid=0.
  - Flush: any source with in_valid & ~in_startofpacket & in_enable gets in_ready=1 in IDLE. Its beat is discarded and sync_err<=1.
  - Sources with SOP pending see in_ready=0.
- LOCK (g=grant_idx):
  - out_valid = in_valid[g]; out_data/SOP/EOP = source g fields; in_ready[g] = out_ready; all other in_ready=0.
  - Zero-cycle latency, purely combinational forwarding.
  - On out_valid & out_ready & out_endofpacket: next state IDLE, last_grant<=g, grant_valid<=0. grant_idx holds its value.
  - Single-beat packet (SOP & EOP together) ends the lock in the same cycle.
- An SOP beat seen mid-lock on the granted source is forwarded unchanged; the arbiter does not police it.
- in_enable deasserted during LOCK does not abort; the packet completes.
- Back-pressure: lock persists indefinitely while out_ready=0 or in_valid[g]=0.
- sync_err:
  - Set by flush, cleared by err_clr.
  - Flush and err_clr in the same cycle: set wins.
- Fairness: after source g finishes, g has the lowest priority. With all sources requesting continuously, the grant order is 0,1,...,NUM_IN-1,0,...

Optional Feature:
- Macro ST_ARB_PKT_CNT_EN.
- Defined: pkt_count[i] increments on each accepted EOP beat from source i and wraps at 2^CNT_W. Cleared by reset only.
- Undefined: no counters are synthesized and pkt_count is tied to 0. Port list is unchanged.

Decomposition:
- Package st_arb_pkg holds:
  - state enum (IDLE, LOCK)
  - MAX_IN=4
  - GIDX_W=2
  - default DATA_W/CNT_W constants
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[NUM_IN], last[GIDX_W].
  - Outputs: any, idx.
  - Reusable by later schedulers.

Test Plan:
- NUM_IN=2, both present 4-beat packets at once after reset -> source 0 forwarded first, 1 idle bubble, then source 1. grant_idx sequence 0 then 1. Output beats in order, no interleave.
- Source 1 holds valid continuously; out_ready toggles 1,0,0,1 mid-packet -> beats stall without loss, in_ready[1] mirrors out_ready, in_ready[0]=0 throughout.
- Single-beat packet (SOP=EOP=1, data 0xA5A5A5) on source 0 -> exactly one output beat with SOP and EOP. Back in IDLE the next cycle.
- Source 0 drives valid with SOP=0 (data 0x123456) while idle -> beat flushed, out_valid stays 0, sync_err=1. err_clr pulse -> sync_err=0.
- in_enable[0] dropped at beat 2 of a 4-beat packet from source 0 -> packet completes. The next grant goes to source 1 only.
- reset_n low for one cycle mid-packet -> out_valid=0, grant_valid=0 the next cycle. A fresh SOP on source 0 is then granted. With ST_ARB_PKT_CNT_EN, pkt_count reads 0 before any EOP.
